byte_word_packer: RTL and testbench

- Packs a valid/ready stream of bytes into 32-bit words laid out as `genericUnion_t` from `demonstration_pkg` (`data[31:0]` = `{byte3, byte2, byte1, byte0}`).
- Sits directly upstream of any consumer of `genericUnion_t`.
- Sustains one byte per cycle with a one-word output register, so assembly continues while a finished word waits.

---
 rtl/byte_word_packer.sv | 118 +++++++++++
 tb/tb_byte_word_packer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_word_packer.sv
// Packs a valid/ready byte stream into 32-bit genericUnion_t words with a one-word output register.
// Optional BYTE_PACKER_LAST_EN adds in_last (early word completion) and the out_keep lane mask.
module byte_word_packer #(
  parameter int unsigned FIRST_BYTE_MSB = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
`ifdef BYTE_PACKER_LAST_EN
  input  logic        in_last,
`endif
  output logic        out_valid,
  input  logic        out_ready,
`ifdef BYTE_PACKER_LAST_EN
  output logic [3:0]  out_keep,
`endif
  output logic [31:0] out_data
);

  logic [1:0]       cnt_q, cnt_d;
  logic [2:0][7:0]  asm_q, asm_d;
  logic [3:0][7:0]  data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_byte;
  logic             completes;
  logic             accept;
`ifdef BYTE_PACKER_LAST_EN
  logic [3:0]       keep_q, keep_d;
`endif

  // Byte position within a word (arrival order) to output lane.
  function automatic logic [1:0] lane_of(input logic [1:0] pos);
    return (FIRST_BYTE_MSB != 0) ? ~pos : pos;
  endfunction

`ifdef BYTE_PACKER_LAST_EN
  assign last_byte = in_last;
`else
  assign last_byte = 1'b0;
`endif

  assign completes = (cnt_q == 2'd3) || last_byte;
  assign in_ready  = !(completes && valid_q && !out_ready);
  assign accept    = in_valid && in_ready;

  always_comb begin
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    data_d  = data_q;
    valid_d = valid_q;
`ifdef BYTE_PACKER_LAST_EN
    keep_d  = keep_q;
`endif
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      if (completes) begin
        // Positions at or above cnt are unfilled and stay zero.
        data_d = '0;
`ifdef BYTE_PACKER_LAST_EN
        keep_d = '0;
`endif
        for (int unsigned p = 0; p < 3; p++) begin
          if (p[1:0] < cnt_q) begin
            data_d[lane_of(p[1:0])] = asm_q[p[1:0]];
`ifdef BYTE_PACKER_LAST_EN
            keep_d[lane_of(p[1:0])] = 1'b1;
`endif
          end
        end
        data_d[lane_of(cnt_q)] = in_data;
`ifdef BYTE_PACKER_LAST_EN
        keep_d[lane_of(cnt_q)] = 1'b1;
`endif
        valid_d = 1'b1;
        cnt_d   = 2'd0;
        asm_d   = '0;
      end else begin
        for (int unsigned p = 0; p < 3; p++) begin
          if (p[1:0] == cnt_q) begin
            asm_d[p[1:0]] = in_data;
          end
        end
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef BYTE_PACKER_LAST_EN
      keep_q  <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef BYTE_PACKER_LAST_EN
      keep_q  <= keep_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
`ifdef BYTE_PACKER_LAST_EN
  assign out_keep  = keep_q;
`endif

endmodule

// File: tb/tb_byte_word_packer.sv
// Bench for byte_word_packer: both lane orders side by side, directed steps then random traffic
// checked against a byte-queue reference model.
module tb_byte_word_packer;

`ifdef BYTE_PACKER_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_last, out_ready;
  logic [7:0]  in_data;
  logic        rdy1, rdy0, ov1, ov0;
  logic [31:0] od1, od0;
`ifdef BYTE_PACKER_LAST_EN
  logic [3:0]  ok1, ok0;
`endif

  always #5 clk = ~clk;

  byte_word_packer #(.FIRST_BYTE_MSB(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
`ifdef BYTE_PACKER_LAST_EN
    .in_last(in_last), .out_keep(ok1),
`endif
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1)
  );

  byte_word_packer #(.FIRST_BYTE_MSB(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
`ifdef BYTE_PACKER_LAST_EN
    .in_last(in_last), .out_keep(ok0),
`endif
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0)
  );

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  logic [7:0]  part[$];
  logic [31:0] e1q[$], e0q[$];
  logic [3:0]  k1q[$], k0q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_word(input logic [7:0] b[$], input bit msb);
    logic [31:0] w = 32'h0;
    for (int k = 0; k < b.size(); k++)
      w |= 32'(b[k]) << (msb ? 8 * (3 - k) : 8 * k);
    return w;
  endfunction

  function automatic logic [3:0] pack_keep(input int n, input bit msb);
    logic [3:0] m = 4'h0;
    for (int k = 0; k < n; k++)
      m |= 4'(1) << (msb ? 3 - k : k);
    return m;
  endfunction

  always @(negedge clk) begin : monitor
    bit complete, erdy;
    if (mon_en) begin
      complete = (part.size() == 3) || (LAST_EN && in_last);
      erdy     = !(complete && e1q.size() != 0 && !out_ready);
      chk("in_ready_msb", 32'(rdy1), 32'(erdy));
      chk("in_ready_lsb", 32'(rdy0), 32'(erdy));
      chk("out_valid_msb", 32'(ov1), 32'(e1q.size() != 0));
      chk("out_valid_lsb", 32'(ov0), 32'(e0q.size() != 0));
      if (e1q.size() != 0) begin
        chk("out_data_msb", od1, e1q[0]);
        chk("out_data_lsb", od0, e0q[0]);
`ifdef BYTE_PACKER_LAST_EN
        chk("out_keep_msb", 32'(ok1), 32'(k1q[0]));
        chk("out_keep_lsb", 32'(ok0), 32'(k0q[0]));
`endif
      end
      if (!rst_n) begin
        part.delete(); e1q.delete(); e0q.delete(); k1q.delete(); k0q.delete();
      end else begin
        if (e1q.size() != 0 && out_ready) begin
          void'(e1q.pop_front()); void'(e0q.pop_front());
          void'(k1q.pop_front()); void'(k0q.pop_front());
        end
        if (in_valid && erdy) begin
          part.push_back(in_data);
          if (complete) begin
            e1q.push_back(pack_word(part, 1'b1));
            e0q.push_back(pack_word(part, 1'b0));
            k1q.push_back(pack_keep(part.size(), 1'b1));
            k0q.push_back(pack_keep(part.size(), 1'b0));
            part.delete();
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic l);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = rdy1;
      @(posedge clk);
      #1;
    end
    chk("send_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ov1), 32'd0);
    chk("rst_out_data", od1, 32'h0);
    chk("rst_in_ready", 32'(rdy1), 32'd1);
`ifdef BYTE_PACKER_LAST_EN
    chk("rst_out_keep", 32'(ok1), 32'h0);
`endif
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Back-to-back full word, both lane orders
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
    chk("word1_valid", 32'(ov1), 32'd1);
    chk("word1_msb", od1, 32'hAABBCCDD);
    chk("word1_lsb", od0, 32'hDDCCBBAA);
    @(posedge clk); #1;
    chk("word1_drained", 32'(ov1), 32'd0);

    // Stall: held word, three more bytes accepted, fourth waits
    out_ready = 1'b0;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    chk("stall_word", od1, 32'h01020304);
    send(8'h05, 1'b0); send(8'h06, 1'b0); send(8'h07, 1'b0);
    in_valid = 1'b1; in_data = 8'h08;
    @(negedge clk);
    chk("stall_in_ready", 32'(rdy1), 32'd0);
    chk("stall_hold", od1, 32'h01020304);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(rdy1), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("release_valid", 32'(ov1), 32'd1);
    chk("release_word", od1, 32'h05060708);
    @(posedge clk); #1;

    // Reset discards a partial word
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_valid", 32'(ov1), 32'd0);
    chk("midrst_ready", 32'(rdy1), 32'd1);
    send(8'h0A, 1'b0); send(8'h0B, 1'b0); send(8'h0C, 1'b0); send(8'h0D, 1'b0);
    chk("postrst_msb", od1, 32'h0A0B0C0D);
    chk("postrst_lsb", od0, 32'h0D0C0B0A);

`ifdef BYTE_PACKER_LAST_EN
    send(8'h11, 1'b0); send(8'h22, 1'b1);
    chk("last2_msb", od1, 32'h11220000);
    chk("last2_keep_msb", 32'(ok1), 32'hC);
    chk("last2_lsb", od0, 32'h00002211);
    chk("last2_keep_lsb", 32'(ok0), 32'h3);
    send(8'h33, 1'b0); send(8'h44, 1'b0); send(8'h55, 1'b0); send(8'h66, 1'b0);
    chk("after_last_msb", od1, 32'h33445566);
    chk("after_last_keep", 32'(ok1), 32'hF);
    send(8'h5A, 1'b1);
    chk("last1_msb", od1, 32'h5A000000);
    chk("last1_keep", 32'(ok1), 32'h8);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b1);
    chk("last4_msb", od1, 32'h01020304);
    chk("last4_keep", 32'(ok1), 32'hF);
`endif

    // Random traffic against the reference model
    repeat (600) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_last   = LAST_EN && ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rst_n     = ($urandom_range(0, 99) != 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
